// File: rtl/imm_pipe_if.sv
// Handshake bundle for imm_pipe: upstream entry (inst/format/tag) and downstream immediate.
// Format width follows the IMM_ZICSR_EN build macro (7 bits when defined, 6 otherwise).
interface imm_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
`ifdef IMM_ZICSR_EN
  localparam int FMT_W = 7;
`else
  localparam int FMT_W = 6;
`endif

  logic             i_flush;
  logic             i_valid;
  logic             o_ready;
  logic [31:0]      i_inst;
  logic [FMT_W-1:0] i_format;
  logic [TAG_W-1:0] i_tag;
  logic             o_valid;
  logic             i_ready;
  logic [XLEN-1:0]  o_immediate;
  logic [TAG_W-1:0] o_tag;
  logic             o_fmt_err;

  modport slave (
    input  i_flush, i_valid, i_inst, i_format, i_tag, i_ready,
    output o_ready, o_valid, o_immediate, o_tag, o_fmt_err
  );

  modport master (
    output i_flush, i_valid, i_inst, i_format, i_tag, i_ready,
    input  o_ready, o_valid, o_immediate, o_tag, o_fmt_err
  );
endinterface

// File: rtl/imm_pipe.sv
// Registered RISC-V immediate generator with a two-entry skid buffer and synchronous flush.
// Build macro IMM_ZICSR_EN adds the Z-type (CSR uimm) format on i_format[6].
module imm_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  imm_pipe_if.slave   bus
);
`ifdef IMM_ZICSR_EN
  localparam int FMT_W = 7;
`else
  localparam int FMT_W = 6;
`endif

  localparam logic [FMT_W-1:0] FMT_R = FMT_W'(32'd1);
  localparam logic [FMT_W-1:0] FMT_I = FMT_W'(32'd2);
  localparam logic [FMT_W-1:0] FMT_S = FMT_W'(32'd4);
  localparam logic [FMT_W-1:0] FMT_B = FMT_W'(32'd8);
  localparam logic [FMT_W-1:0] FMT_U = FMT_W'(32'd16);
  localparam logic [FMT_W-1:0] FMT_J = FMT_W'(32'd32);
`ifdef IMM_ZICSR_EN
  localparam logic [FMT_W-1:0] FMT_Z = FMT_W'(32'd64);
`endif

  typedef struct packed {
    logic             err;
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
  } entry_t;

  // Decoded immediate is built at 64 bits and truncated, so XLEN=32 needs no special case.
  function automatic logic [XLEN:0] decode_imm(input logic [31:7] inst,
                                               input logic [FMT_W-1:0] fmt);
    logic [63:0] imm_v;
    logic        err_v;
    logic        s;
    s     = inst[31];
    imm_v = 64'd0;
    err_v = 1'b0;
    case (fmt)
      FMT_R: imm_v = 64'd0;
      FMT_I: imm_v = {{52{s}}, inst[31:20]};
      FMT_S: imm_v = {{52{s}}, inst[31:25], inst[11:7]};
      FMT_B: imm_v = {{51{s}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U: imm_v = {{32{s}}, inst[31:12], 12'd0};
      FMT_J: imm_v = {{43{s}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
`ifdef IMM_ZICSR_EN
      FMT_Z: imm_v = {59'd0, inst[19:15]};
`endif
      default: begin
        imm_v = 64'd0;
        err_v = 1'b1;
      end
    endcase
    return {err_v, imm_v[XLEN-1:0]};
  endfunction

  logic          out_valid_r;
  logic          skid_valid_r;
  entry_t        out_r;
  entry_t        skid_r;
  entry_t        new_s;
  logic [XLEN:0] dec_s;
  logic          accept_s;
  logic          xfer_s;
  logic          move_s;
  logic          load_out_s;
  logic          load_skid_s;
  logic          out_valid_nxt_s;
  logic          skid_valid_nxt_s;
  logic          unused_opcode_s;

  assign unused_opcode_s = ^bus.i_inst[6:0];
  assign dec_s    = decode_imm(bus.i_inst[31:7], bus.i_format);
  assign new_s    = {dec_s[XLEN], dec_s[XLEN-1:0], bus.i_tag};
  assign accept_s = bus.i_valid && !skid_valid_r;
  assign xfer_s   = out_valid_r && bus.i_ready;

  // Next occupancy and load selects; flush overrides every accept and transfer.
  always_comb begin
    out_valid_nxt_s  = out_valid_r;
    skid_valid_nxt_s = skid_valid_r;
    move_s           = 1'b0;
    load_out_s       = 1'b0;
    load_skid_s      = 1'b0;
    if (bus.i_flush) begin
      out_valid_nxt_s  = 1'b0;
      skid_valid_nxt_s = 1'b0;
    end else begin
      move_s           = xfer_s && skid_valid_r;
      load_out_s       = accept_s && (!out_valid_r || xfer_s);
      load_skid_s      = accept_s && out_valid_r && !xfer_s;
      out_valid_nxt_s  = move_s || load_out_s || (out_valid_r && !xfer_s);
      skid_valid_nxt_s = load_skid_s || (skid_valid_r && !xfer_s);
    end
  end

  // Occupancy flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else begin
      out_valid_r  <= out_valid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
    end
  end

  // Entry payloads change only on a load or a skid-to-out move.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_r  <= '0;
      skid_r <= '0;
    end else begin
      if (move_s) begin
        out_r <= skid_r;
      end else if (load_out_s) begin
        out_r <= new_s;
      end else begin
        out_r <= out_r;
      end
      if (load_skid_s) begin
        skid_r <= new_s;
      end else begin
        skid_r <= skid_r;
      end
    end
  end

  assign bus.o_valid     = out_valid_r;
  assign bus.o_ready     = !skid_valid_r;
  assign bus.o_immediate = out_r.imm;
  assign bus.o_tag       = out_r.tag;
  assign bus.o_fmt_err   = out_r.err;
endmodule

// File: tb/tb_imm_pipe.sv
// Self-checking bench for imm_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream
// and are compared against a queue-based reference model.
module tb_imm_pipe;
`ifdef IMM_ZICSR_EN
  localparam int FMT_W = 7;
`else
  localparam int FMT_W = 6;
`endif
  localparam logic [FMT_W-1:0] F_R = FMT_W'(32'd1);
  localparam logic [FMT_W-1:0] F_I = FMT_W'(32'd2);
  localparam logic [FMT_W-1:0] F_S = FMT_W'(32'd4);
  localparam logic [FMT_W-1:0] F_U = FMT_W'(32'd16);
  localparam logic [FMT_W-1:0] F_J = FMT_W'(32'd32);

  typedef struct {
    logic [63:0] imm;
    logic [31:0] tag;
    logic        err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  exp_t q[$];

  imm_pipe_if #(.XLEN(32), .TAG_W(32)) bus32 ();
  imm_pipe_if #(.XLEN(64), .TAG_W(32)) bus64 ();

  imm_pipe #(.XLEN(32), .TAG_W(32)) dut32 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus32));
  imm_pipe #(.XLEN(64), .TAG_W(32)) dut64 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus64));

  assign bus64.i_flush  = bus32.i_flush;
  assign bus64.i_valid  = bus32.i_valid;
  assign bus64.i_inst   = bus32.i_inst;
  assign bus64.i_format = bus32.i_format;
  assign bus64.i_tag    = bus32.i_tag;
  assign bus64.i_ready  = bus32.i_ready;

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference decode: sign extension via signed intermediates of the field's own width.
  function automatic void ref_imm(input logic [31:0] inst, input logic [FMT_W-1:0] fmt,
                                  output logic [63:0] imm, output logic err);
    logic signed [11:0] v12;
    logic signed [12:0] v13;
    logic signed [20:0] v21;
    logic signed [31:0] v32;
    longint t;
    t   = 0;
    err = 1'b0;
    if ($countones(fmt) != 1) begin
      err = 1'b1;
    end else if (fmt[1]) begin
      v12 = inst[31:20]; t = v12;
    end else if (fmt[2]) begin
      v12 = {inst[31:25], inst[11:7]}; t = v12;
    end else if (fmt[3]) begin
      v13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}; t = v13;
    end else if (fmt[4]) begin
      v32 = {inst[31:12], 12'd0}; t = v32;
    end else if (fmt[5]) begin
      v21 = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}; t = v21;
`ifdef IMM_ZICSR_EN
    end else if (fmt[6]) begin
      t = longint'(inst[19:15]);
`endif
    end
    imm = t;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [FMT_W-1:0] fmt,
                       input logic [31:0] tag, input logic rdy, input logic fl);
    bus32.i_valid  = v;
    bus32.i_inst   = inst;
    bus32.i_format = fmt;
    bus32.i_tag    = tag;
    bus32.i_ready  = rdy;
    bus32.i_flush  = fl;
  endtask

  task automatic check_outputs();
    chk("o_valid32", 64'(bus32.o_valid), 64'(q.size() > 0));
    chk("o_valid64", 64'(bus64.o_valid), 64'(q.size() > 0));
    chk("o_ready", 64'(bus32.o_ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      chk("o_tag", 64'(bus32.o_tag), 64'(q[0].tag));
      chk("o_imm32", 64'(bus32.o_immediate), {32'd0, q[0].imm[31:0]});
      chk("o_imm64", bus64.o_immediate, q[0].imm);
      chk("o_fmt_err", 64'(bus32.o_fmt_err), 64'(q[0].err));
    end
  endtask

  // One clock: update the model from the inputs seen at the edge, then check just after it.
  task automatic step();
    logic rdy_exp;
    exp_t e;
    rdy_exp = (q.size() < 2);
    @(posedge clk);
    if (bus32.i_flush) begin
      q.delete();
    end else begin
      if (q.size() > 0 && bus32.i_ready) void'(q.pop_front());
      if (bus32.i_valid && rdy_exp) begin
        ref_imm(bus32.i_inst, bus32.i_format, e.imm, e.err);
        e.tag = bus32.i_tag;
        q.push_back(e);
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_valid"}, 64'(bus32.o_valid), 64'd0);
    chk({name, "_ready"}, 64'(bus32.o_ready), 64'd1);
    chk({name, "_imm"}, bus64.o_immediate, 64'd0);
    chk({name, "_tag"}, 64'(bus32.o_tag), 64'd0);
    chk({name, "_err"}, 64'(bus32.o_fmt_err), 64'd0);
  endtask

  initial begin
    logic [FMT_W-1:0] fmt;
    drive(1'b0, 32'd0, F_R, 32'd0, 1'b1, 1'b0);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Plan vectors, back-to-back with i_ready high.
    drive(1'b1, 32'hFFF00093, F_I, 32'h100, 1'b1, 1'b0); step();
    chk("plan_i_imm", 64'(bus32.o_immediate), 64'hFFFFFFFF);
    chk("plan_i_tag", 64'(bus32.o_tag), 64'h100);
    drive(1'b1, 32'hFE112E23, F_S, 32'h101, 1'b1, 1'b0); step();
    chk("plan_s_imm", 64'(bus32.o_immediate), 64'hFFFFFFFC);
    drive(1'b1, 32'h001000EF, F_J, 32'h102, 1'b1, 1'b0); step();
    chk("plan_j_imm", 64'(bus32.o_immediate), 64'h00000800);
    drive(1'b1, 32'h800000B7, F_U, 32'h103, 1'b1, 1'b0); step();
    chk("plan_u_imm64", bus64.o_immediate, 64'hFFFFFFFF80000000);
`ifdef IMM_ZICSR_EN
    drive(1'b1, 32'h7E0FD073, FMT_W'(32'd64), 32'h104, 1'b1, 1'b0); step();
    chk("plan_z_imm", 64'(bus32.o_immediate), 64'h1F);
`endif
    drive(1'b1, 32'hFFFFFFFF, FMT_W'(32'd6), 32'h105, 1'b1, 1'b0); step();
    chk("plan_multi_imm", 64'(bus32.o_immediate), 64'd0);
    chk("plan_multi_err", 64'(bus32.o_fmt_err), 64'd1);
    drive(1'b1, 32'hFFFFFFFF, F_R, 32'h106, 1'b1, 1'b0); step();
    chk("plan_r_err", 64'(bus32.o_fmt_err), 64'd0);
    drive(1'b1, 32'hFFFFFFFF, FMT_W'(32'd0), 32'h107, 1'b1, 1'b0); step();
    chk("plan_zero_err", 64'(bus32.o_fmt_err), 64'd1);
    drive(1'b0, 32'd0, F_R, 32'd0, 1'b1, 1'b0); step();

    // Backpressure: tags 1,2 fill the stage, 3 waits, then all drain in order.
    drive(1'b1, 32'h00100093, F_I, 32'd1, 1'b0, 1'b0); step();
    drive(1'b1, 32'h00200093, F_I, 32'd2, 1'b0, 1'b0); step();
    drive(1'b1, 32'h00300093, F_I, 32'd3, 1'b0, 1'b0); step();
    chk("bp_ready_low", 64'(bus32.o_ready), 64'd0);
    step();
    chk("bp_tag_stable", 64'(bus32.o_tag), 64'd1);
    drive(1'b1, 32'h00300093, F_I, 32'd3, 1'b1, 1'b0); step();
    chk("bp_tag2", 64'(bus32.o_tag), 64'd2);
    step();
    chk("bp_tag3", 64'(bus32.o_tag), 64'd3);
    drive(1'b0, 32'd0, F_R, 32'd0, 1'b1, 1'b0); step(); step();

    // Flush with both entries full and a new entry offered.
    drive(1'b1, 32'h00A00093, F_I, 32'hA, 1'b0, 1'b0); step();
    drive(1'b1, 32'h00B00093, F_I, 32'hB, 1'b0, 1'b0); step();
    drive(1'b1, 32'h00C00093, F_I, 32'hC, 1'b0, 1'b1); step();
    chk("flush_valid", 64'(bus32.o_valid), 64'd0);
    chk("flush_ready", 64'(bus32.o_ready), 64'd1);
    drive(1'b0, 32'd0, F_R, 32'd0, 1'b1, 1'b0); step(); step();

    // Asynchronous reset with both entries full.
    drive(1'b1, 32'h00D00093, F_I, 32'hD, 1'b0, 1'b0); step();
    drive(1'b1, 32'h00E00093, F_I, 32'hE, 1'b0, 1'b0); step();
    drive(1'b0, 32'd0, F_R, 32'd0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h05500093, F_I, 32'h55, 1'b1, 1'b0); step();
    chk("rst_first_valid", 64'(bus32.o_valid), 64'd1);
    chk("rst_first_tag", 64'(bus32.o_tag), 64'h55);

    // Randomised traffic, flushes and formats.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) fmt = FMT_W'($urandom);
      else fmt = FMT_W'(32'd1) << $urandom_range(0, FMT_W - 1);
      drive($urandom_range(0, 3) != 0, $urandom, fmt, $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
